// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   - bus widths of the EX->MEM, MEM->WB and MEM->ID forwarding buses
//   - encoding of the per-instruction response-capture state
//   - bit positions of the load-type field {ld_w, ld_b, ld_h, ld_bu, ld_hu}
//   - helper that sign/zero-extends a byte or halfword to 32 bits
// ----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int unsigned EX_MEM_LEN = 77;
    localparam int unsigned MEM_WB_LEN = 70;
    localparam int unsigned MEM_RF_LEN = 39;

    // Response capture state of the instruction currently held in MEM.
    typedef enum logic [1:0] {
        StIdle = 2'd0,  // no instruction
        StWait = 2'd1,  // memory access issued, response not yet seen
        StHave = 2'd2   // result available (response buffered or no access)
    } resp_state_e;

    // Field positions inside EX_mem_ld_inst.
    localparam int unsigned LdWBit  = 4;
    localparam int unsigned LdBBit  = 3;
    localparam int unsigned LdHBit  = 2;
    localparam int unsigned LdBuBit = 1;
    localparam int unsigned LdHuBit = 0;

    // Extends the low byte (is_half=0) or the halfword (is_half=1) of v.
    function automatic logic [31:0] load_extend(input logic [15:0] v,
                                                input logic        is_half,
                                                input logic        is_signed);
        logic [31:0] res;
        if (is_half) begin
            res = {{16{is_signed & v[15]}}, v};
        end else begin
            res = {{24{is_signed & v[7]}}, v[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// ----------------------------------------------------------------------------
// mem_load_align
// Combinational load-data alignment: picks the addressed byte or halfword out
// of the read word and sign- or zero-extends it; ld.w passes the word through.
// With no load bit set the output is a don't-care (the raw word is passed).
// Misaligned halfword/word accesses are not checked.
// Ports:
//   i_rdata    [31:0] raw data SRAM read word
//   i_addr     [1:0]  low address bits of the access
//   i_ld_inst  [4:0]  {ld_w, ld_b, ld_h, ld_bu, ld_hu}, one-hot or zero
//   o_data     [31:0] aligned, extended load data
// ----------------------------------------------------------------------------
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [4:0]  i_ld_inst,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        if (i_ld_inst[LdBBit]) begin
            o_data = load_extend({8'h00, w_byte}, 1'b0, 1'b1);
        end else if (i_ld_inst[LdBuBit]) begin
            o_data = load_extend({8'h00, w_byte}, 1'b0, 1'b0);
        end else if (i_ld_inst[LdHBit]) begin
            o_data = load_extend(w_half, 1'b1, 1'b1);
        end else if (i_ld_inst[LdHuBit]) begin
            o_data = load_extend(w_half, 1'b1, 1'b0);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage between EX and WB. Latches the instruction
// leaving EX, captures the data SRAM read response exactly once, aligns load
// data, selects load data or ALU result and offers it to WB under the
// valid/allowin handshake. Also drives the MEM forwarding bus for ID.
//
// Configuration macro: MEM_DATA_OK_EN
//   defined   - the response is data_sram_data_ok; MEM may wait indefinitely.
//   undefined - the response is the first MEM cycle; data_sram_data_ok unused.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   MEM_allowin        out  MEM can accept an instruction this cycle
//   EX_MEM_valid       in   EX presents a valid instruction
//   EX_rf_bus  [38:0]  in   {res_from_mem, rf_we, rf_waddr, alu_result}
//   EX_pc      [31:0]  in   PC of the EX instruction
//   EX_mem_ld_inst[4:0]in   {ld_w, ld_b, ld_h, ld_bu, ld_hu}
//   EX_mem_req         in   EX issued a data SRAM access
//   data_sram_rdata    in   SRAM read data
//   data_sram_data_ok  in   SRAM response strobe (MEM_DATA_OK_EN only)
//   WB_allowin         in   WB can accept
//   MEM_WB_valid       out  valid instruction offered to WB
//   MEM_WB_bus [69:0]  out  {rf_we, rf_waddr, final_result, pc}
//   MEM_rf_bus [38:0]  out  {load_pending, rf_we&valid, rf_waddr, final_result}
// ----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  MEM_allowin,
    input  logic                  EX_MEM_valid,
    input  logic [MEM_RF_LEN-1:0] EX_rf_bus,
    input  logic [31:0]           EX_pc,
    input  logic [4:0]            EX_mem_ld_inst,
    input  logic                  EX_mem_req,
    input  logic [31:0]           data_sram_rdata,
    input  logic                  data_sram_data_ok,
    input  logic                  WB_allowin,
    output logic                  MEM_WB_valid,
    output logic [MEM_WB_LEN-1:0] MEM_WB_bus,
    output logic [MEM_RF_LEN-1:0] MEM_rf_bus
);

    // Pipeline register and capture state.
    logic        r_valid;
    resp_state_e r_state;
    logic [31:0] r_rdata_buf;
    logic        r_res_from_mem;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_alu_result;
    logic [31:0] r_pc;
    logic [4:0]  r_ld_inst;

    logic        w_resp_evt;
    logic        w_ready_go;
    logic [31:0] w_rdata_src;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;
    logic        w_load_pending;

`ifdef MEM_DATA_OK_EN
    assign w_resp_evt = r_valid & (r_state == StWait) & data_sram_data_ok;
`else
    // WAIT only ever lasts the first MEM cycle, which is the response cycle.
    logic w_unused_data_ok;
    assign w_unused_data_ok = data_sram_data_ok;
    assign w_resp_evt       = r_valid & (r_state == StWait);
`endif

    assign w_ready_go   = (r_state == StHave) | w_resp_evt;
    assign MEM_allowin  = ~r_valid | (w_ready_go & WB_allowin);
    assign MEM_WB_valid = r_valid & w_ready_go;

    // In the response cycle use the live read data; afterwards only the buffer,
    // so later rdata changes during a WB stall cannot leak into the result.
    assign w_rdata_src = (r_state == StHave) ? r_rdata_buf : data_sram_rdata;

    mem_load_align u_load_align (
        .i_rdata   (w_rdata_src),
        .i_addr    (r_alu_result[1:0]),
        .i_ld_inst (r_ld_inst),
        .o_data    (w_load_data)
    );

    assign w_final_result = r_res_from_mem ? w_load_data : r_alu_result;
    assign w_load_pending = r_valid & r_res_from_mem & ~w_ready_go;

    assign MEM_WB_bus = {r_rf_we, r_rf_waddr, w_final_result, r_pc};
    assign MEM_rf_bus = {w_load_pending, r_rf_we & r_valid, r_rf_waddr, w_final_result};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid        <= 1'b0;
            r_state        <= StIdle;
            r_rdata_buf    <= 32'h0;
            r_res_from_mem <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= 5'h0;
            r_alu_result   <= 32'h0;
            r_pc           <= 32'h0;
            r_ld_inst      <= 5'h0;
        end else begin
            if (w_resp_evt) begin
                r_rdata_buf <= data_sram_rdata;
            end
            if (MEM_allowin) begin
                r_valid <= EX_MEM_valid;
                if (EX_MEM_valid) begin
                    // A departing instruction is replaced in the same edge, so
                    // the state comes straight from the incoming request.
                    r_state        <= EX_mem_req ? StWait : StHave;
                    r_res_from_mem <= EX_rf_bus[38];
                    r_rf_we        <= EX_rf_bus[37];
                    r_rf_waddr     <= EX_rf_bus[36:32];
                    r_alu_result   <= EX_rf_bus[31:0];
                    r_pc           <= EX_pc;
                    r_ld_inst      <= EX_mem_ld_inst;
                end else begin
                    r_state <= StIdle;
                end
            end else if (w_resp_evt) begin
                r_state <= StHave;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        MEM_allowin;
    logic        EX_MEM_valid;
    logic [38:0] EX_rf_bus;
    logic [31:0] EX_pc;
    logic [4:0]  EX_mem_ld_inst;
    logic        EX_mem_req;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic        WB_allowin;
    logic        MEM_WB_valid;
    logic [69:0] MEM_WB_bus;
    logic [38:0] MEM_rf_bus;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .MEM_allowin       (MEM_allowin),
        .EX_MEM_valid      (EX_MEM_valid),
        .EX_rf_bus         (EX_rf_bus),
        .EX_pc             (EX_pc),
        .EX_mem_ld_inst    (EX_mem_ld_inst),
        .EX_mem_req        (EX_mem_req),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok),
        .WB_allowin        (WB_allowin),
        .MEM_WB_valid      (MEM_WB_valid),
        .MEM_WB_bus        (MEM_WB_bus),
        .MEM_rf_bus        (MEM_rf_bus)
    );

    typedef struct {
        string       name;
        logic [4:0]  ld;
        logic        res;
        logic        req;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          stall;
        logic [31:0] scramble;
        logic [31:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load result straight from the ISA rules, using plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [4:0] ld, input logic [1:0] a,
                                               input logic [31:0] rd, input logic res,
                                               input logic [31:0] alu);
        logic [31:0] v;
        if (!res) return alu;
        case (ld)
            5'b10000: return rd;
            5'b01000, 5'b00010: begin
                v = (rd >> (8 * a)) & 32'hFF;
                if (ld == 5'b01000 && v >= 32'd128) return v - 32'd256;
                return v;
            end
            5'b00100, 5'b00001: begin
                v = (rd >> (16 * a[1])) & 32'hFFFF;
                if (ld == 5'b00100 && v >= 32'd32768) return v - 32'h10000;
                return v;
            end
            default: return rd;
        endcase
    endfunction

    task automatic ex_idle();
        EX_MEM_valid   = 1'b0;
        EX_rf_bus      = 39'h0;
        EX_pc          = 32'h0;
        EX_mem_ld_inst = 5'h0;
        EX_mem_req     = 1'b0;
    endtask

    task automatic ex_put(input vec_t v);
        EX_MEM_valid   = 1'b1;
        EX_rf_bus      = {v.res, v.we, v.waddr, v.alu};
        EX_pc          = v.pc;
        EX_mem_ld_inst = v.ld;
        EX_mem_req     = v.req;
    endtask

    // One instruction through an empty MEM, with an optional WB stall.
    task automatic run_one(input vec_t v);
        @(negedge clk);
        ex_put(v);
        data_sram_data_ok = 1'b0;
        WB_allowin        = 1'b1;
        #1 check({v.name, " allowin_empty"}, 70'(MEM_allowin), 70'(1'b1));
        @(negedge clk);
        ex_idle();
        data_sram_rdata   = v.rdata;
        data_sram_data_ok = v.req;
        WB_allowin        = (v.stall == 0);
        #1;
        check({v.name, " wb_valid"}, 70'(MEM_WB_valid), 70'(1'b1));
        check({v.name, " wb_bus"}, MEM_WB_bus, {v.we, v.waddr, v.exp, v.pc});
        check({v.name, " rf_bus"}, 70'(MEM_rf_bus), 70'({1'b0, v.we, v.waddr, v.exp}));
        check({v.name, " allowin"}, 70'(MEM_allowin), 70'(v.stall == 0));
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = v.scramble;
            WB_allowin        = (s == v.stall - 1);
            #1;
            check({v.name, " stall_valid"}, 70'(MEM_WB_valid), 70'(1'b1));
            check({v.name, " stall_result"}, 70'(MEM_WB_bus[63:32]), 70'(v.exp));
            check({v.name, " stall_allowin"}, 70'(MEM_allowin), 70'(s == v.stall - 1));
        end
        @(negedge clk);
        WB_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        #1;
        check({v.name, " drained"}, 70'(MEM_WB_valid), 70'(1'b0));
    endtask

    vec_t vecs[9];
    vec_t a, b;

    initial begin
        vecs[0] = '{"ld_b_a3",   5'b01000, 1, 1, 1, 5'd1, 32'h0000_1003, 32'h1c00_0000,
                    32'h80FF_1234, 0, 32'h0, 32'hFFFF_FF80};
        vecs[1] = '{"ld_hu_a2",  5'b00001, 1, 1, 1, 5'd2, 32'h0000_2002, 32'h1c00_0004,
                    32'h8001_0000, 0, 32'h0, 32'h0000_8001};
        vecs[2] = '{"ld_h_a2",   5'b00100, 1, 1, 1, 5'd3, 32'h0000_2002, 32'h1c00_0008,
                    32'h8001_0000, 0, 32'h0, 32'hFFFF_8001};
        vecs[3] = '{"ld_w_stall", 5'b10000, 1, 1, 1, 5'd4, 32'h0000_3000, 32'h1c00_000c,
                    32'h1234_5678, 3, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[4] = '{"add",       5'b00000, 0, 0, 1, 5'd5, 32'h0000_0042, 32'h1c00_0010,
                    32'hFFFF_FFFF, 0, 32'h0, 32'h0000_0042};
        vecs[5] = '{"ld_bu_a1",  5'b00010, 1, 1, 1, 5'd6, 32'h0000_4001, 32'h1c00_0014,
                    32'h1234_A5FF, 0, 32'h0, 32'h0000_00A5};
        vecs[6] = '{"ld_b_a0",   5'b01000, 1, 1, 1, 5'd7, 32'h0000_4000, 32'h1c00_0018,
                    32'hFFFF_FF7F, 0, 32'h0, 32'h0000_007F};
        vecs[7] = '{"ld_h_a0",   5'b00100, 1, 1, 0, 5'd8, 32'h0000_4000, 32'h1c00_001c,
                    32'h0000_8000, 1, 32'h0, 32'hFFFF_8000};
        vecs[8] = '{"store",     5'b00000, 0, 1, 0, 5'd0, 32'h0000_5004, 32'h1c00_0020,
                    32'hAAAA_5555, 0, 32'h0, 32'h0000_5004};

        resetn            = 1'b0;
        ex_idle();
        data_sram_rdata   = 32'h0;
        data_sram_data_ok = 1'b0;
        WB_allowin        = 1'b1;

        // Reset state.
        @(negedge clk);
        #1;
        check("rst allowin", 70'(MEM_allowin), 70'(1'b1));
        check("rst wb_valid", 70'(MEM_WB_valid), 70'(1'b0));
        check("rst wb_bus", MEM_WB_bus, 70'h0);
        check("rst rf_bus", 70'(MEM_rf_bus), 70'h0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) run_one(vecs[i]);

        // Back-to-back: B enters the same edge A leaves.
        a = '{"b2b_a", 5'b00000, 0, 0, 1, 5'd3, 32'h0000_0011, 32'h0000_0100,
              32'h0, 0, 32'h0, 32'h0000_0011};
        b = '{"b2b_b", 5'b00010, 1, 1, 1, 5'd4, 32'h0000_0801, 32'h0000_0104,
              32'h0000_C300, 0, 32'h0, 32'h0000_00C3};
        @(negedge clk);
        ex_put(a);
        WB_allowin = 1'b1;
        @(negedge clk);
        ex_put(b);
        #1;
        check("b2b a_bus", MEM_WB_bus, {a.we, a.waddr, a.exp, a.pc});
        check("b2b a_allowin", 70'(MEM_allowin), 70'(1'b1));
        @(negedge clk);
        ex_idle();
        data_sram_rdata   = b.rdata;
        data_sram_data_ok = 1'b1;
        #1;
        check("b2b b_valid", 70'(MEM_WB_valid), 70'(1'b1));
        check("b2b b_bus", MEM_WB_bus, {b.we, b.waddr, b.exp, b.pc});
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1 check("b2b drained", 70'(MEM_WB_valid), 70'(1'b0));

        // Stray data_ok while empty.
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5A5A_5A5A;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        check("stray wb_valid", 70'(MEM_WB_valid), 70'(1'b0));
        check("stray allowin", 70'(MEM_allowin), 70'(1'b1));

`ifdef MEM_DATA_OK_EN
        // Late response: four cycles of load_pending before data_ok.
        a = '{"late", 5'b10000, 1, 1, 1, 5'd9, 32'h0000_2000, 32'h0000_0200,
              32'hCAFE_F00D, 0, 32'h0, 32'hCAFE_F00D};
        @(negedge clk);
        ex_put(a);
        @(negedge clk);
        ex_idle();
        data_sram_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("late pending", 70'(MEM_rf_bus[38]), 70'(1'b1));
            check("late wb_valid", 70'(MEM_WB_valid), 70'(1'b0));
            check("late allowin", 70'(MEM_allowin), 70'(1'b0));
        end
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = a.rdata;
        #1;
        check("late wb_valid_ok", 70'(MEM_WB_valid), 70'(1'b1));
        check("late wb_bus", MEM_WB_bus, {a.we, a.waddr, a.exp, a.pc});
        check("late pending_clr", 70'(MEM_rf_bus[38]), 70'(1'b0));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1 check("late drained", 70'(MEM_WB_valid), 70'(1'b0));
`endif

        // Reset asserted while the load waits for its response.
        a = '{"rst_wait", 5'b10000, 1, 1, 1, 5'd10, 32'h0000_3000, 32'h0000_0300,
              32'h1111_2222, 0, 32'h0, 32'h1111_2222};
        @(negedge clk);
        ex_put(a);
        @(negedge clk);
        ex_idle();
        data_sram_data_ok = 1'b0;
        resetn            = 1'b0;
        #1;
        check("rstw allowin", 70'(MEM_allowin), 70'(1'b1));
        check("rstw wb_valid", 70'(MEM_WB_valid), 70'(1'b0));
        check("rstw wb_bus", MEM_WB_bus, 70'h0);
        check("rstw rf_bus", 70'(MEM_rf_bus), 70'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h3333_4444;
        #1 check("rstw ok_ignored", 70'(MEM_WB_valid), 70'(1'b0));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        check("rstw after_ok", 70'(MEM_WB_valid), 70'(1'b0));
        check("rstw rf_after", 70'(MEM_rf_bus), 70'h0);

        // Random instructions against the reference model.
        for (int n = 0; n < 40; n++) begin
            int kind;
            vec_t v;
            kind       = $urandom_range(0, 6);
            v.name     = $sformatf("rnd%0d", n);
            v.we       = 1'($urandom);
            v.waddr    = 5'($urandom);
            v.alu      = $urandom;
            v.pc       = $urandom;
            v.rdata    = $urandom;
            v.stall    = $urandom_range(0, 3);
            v.scramble = $urandom;
            if (kind < 5) begin
                v.ld  = 5'(1 << kind);
                v.res = 1'b1;
                v.req = 1'b1;
            end else begin
                v.ld  = 5'h0;
                v.res = 1'b0;
                v.req = (kind == 6);
            end
            v.exp = ref_result(v.ld, v.alu[1:0], v.rdata, v.res, v.alu);
            run_one(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
